// File: rtl/cipher_out_serializer.sv
// Two-block ciphertext buffer that drains each 128-bit AES block as four 32-bit
// words over a valid/ready stream, with sticky overflow and a drained-block counter.
module cipher_out_serializer #(
  parameter int MSW_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         overflow,
  output logic [15:0]  blk_count
);

  localparam int DATA_W = 128;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fill_state_e;

  fill_state_e        state_q, state_d;
  logic [DATA_W-1:0]  mem_q [2];
  logic               rd_ptr_q, rd_ptr_d;
  logic               wr_ptr_q, wr_ptr_d;
  logic [1:0]         word_idx_q, word_idx_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        blk_count_q, blk_count_d;

  logic               push, pop, drop, word_hs;
  logic [DATA_W-1:0]  head_blk;

  function automatic logic [WORD_W-1:0] select_word(input logic [DATA_W-1:0] blk,
                                                     input logic [1:0]        idx);
    logic [1:0] lane;
    lane = (MSW_FIRST != 0) ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    select_word = blk[31:0];
      2'd1:    select_word = blk[63:32];
      2'd2:    select_word = blk[95:64];
      default: select_word = blk[127:96];
    endcase
  endfunction

  // in_ready looks only at registered occupancy so the upstream path never sees out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign word_hs   = out_valid & out_ready;
  assign pop       = word_hs & (word_idx_q == 2'd3);
  assign push      = in_valid & in_ready;
  assign drop      = in_valid & ~in_ready;

  assign head_blk  = mem_q[rd_ptr_q];
  assign out_data  = select_word(head_blk, word_idx_q);
  assign out_last  = out_valid & (word_idx_q == 2'd3);
  assign overflow  = overflow_q;
  assign blk_count = blk_count_q;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    word_idx_d  = word_idx_q;
    overflow_d  = overflow_q | drop;
    blk_count_d = blk_count_q;

    case (state_q)
      EMPTY: if (push) state_d = ONE;
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (!push && pop) state_d = EMPTY;
      end
      FULL:    if (pop) state_d = ONE;
      default: state_d = EMPTY;
    endcase

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop) begin
      rd_ptr_d    = ~rd_ptr_q;
      blk_count_d = blk_count_q + 16'd1;
    end
    // two-bit index wraps 3 -> 0 exactly when the head block is popped
    if (word_hs) word_idx_d = word_idx_q + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      word_idx_q  <= 2'd0;
      overflow_q  <= 1'b0;
      blk_count_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      word_idx_q  <= word_idx_d;
      overflow_q  <= overflow_d;
      blk_count_q <= blk_count_d;
    end
  end

  // Block storage carries no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: tb/tb_cipher_out_serializer.sv
// Scoreboard bench: stimulus queues expected words for an MSW-first and an
// LSW-first instance; a negedge monitor checks every handshaken word.
module tb_cipher_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         in_ready, out_valid, out_last, overflow;
  logic [31:0]  out_data;
  logic [15:0]  blk_count;
  logic         l_in_ready, l_out_valid, l_out_last, l_overflow;
  logic [31:0]  l_out_data;
  logic [15:0]  l_blk_count;

  int checks   = 0;
  int failures = 0;
  int exp_blk  = 0;
  logic [32:0] q_msw[$];
  logic [32:0] q_lsw[$];
  logic        stall_q = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  localparam logic [127:0] B0 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] B1 = 128'h10101010_11111111_12121212_13131313;
  localparam logic [127:0] B2 = 128'h20202020_21212121_22222222_23232323;
  localparam logic [127:0] B3 = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] B4 = 128'h40404040_41414141_42424242_43434343;
  localparam logic [127:0] B5 = 128'h50505050_51515151_52525252_53535353;
  localparam logic [127:0] B6 = 128'h60606060_61616161_62626262_63636363;
  localparam logic [127:0] B7 = 128'h70707070_71717171_72727272_73737373;

  always #5 clk = ~clk;

  cipher_out_serializer #(.MSW_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .overflow(overflow),
    .blk_count(blk_count)
  );

  cipher_out_serializer #(.MSW_FIRST(0)) dut_lsw (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(l_in_ready), .out_valid(l_out_valid), .out_ready(out_ready),
    .out_data(l_out_data), .out_last(l_out_last), .overflow(l_overflow),
    .blk_count(l_blk_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected words, hand-listed per block: {last, word}
  task automatic expect_blk(input logic [31:0] w3, input logic [31:0] w2,
                            input logic [31:0] w1, input logic [31:0] w0);
    q_msw.push_back({1'b0, w3}); q_msw.push_back({1'b0, w2});
    q_msw.push_back({1'b0, w1}); q_msw.push_back({1'b1, w0});
    q_lsw.push_back({1'b0, w0}); q_lsw.push_back({1'b0, w1});
    q_lsw.push_back({1'b0, w2}); q_lsw.push_back({1'b1, w3});
  endtask

  task automatic push_blk(input logic [127:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst_n) begin
      exp_blk = 0;
      stall_q = 1'b0;
    end else begin
      chk("blk_count", {16'd0, blk_count}, exp_blk);
      if (stall_q && out_valid) begin
        chk("stall_data", out_data, stall_data);
        chk("stall_last", {31'd0, out_last}, {31'd0, stall_last});
      end
      if (out_valid && out_ready) begin
        if (q_msw.size() == 0) begin
          checks++; failures++;
          $display("FAIL msw_extra_word actual=%h required=none", out_data);
        end else begin
          e = q_msw.pop_front();
          chk("msw_data", out_data, e[31:0]);
          chk("msw_last", {31'd0, out_last}, {31'd0, e[32]});
          if (e[32]) exp_blk++;
        end
      end
      if (l_out_valid && out_ready) begin
        if (q_lsw.size() == 0) begin
          checks++; failures++;
          $display("FAIL lsw_extra_word actual=%h required=none", l_out_data);
        end else begin
          e = q_lsw.pop_front();
          chk("lsw_data", l_out_data, e[31:0]);
          chk("lsw_last", {31'd0, l_out_last}, {31'd0, e[32]});
        end
      end
      stall_q    = out_valid && !out_ready;
      stall_data = out_data;
      stall_last = out_last;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_blk_count", {16'd0, blk_count}, 32'd0);

    // Single block, streaming out one word per cycle
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_blk(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    push_blk(B0);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("first_word", out_data, 32'h00112233);
    chk("first_word_lsw", l_out_data, 32'hCCDDEEFF);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("a_blk_count", {16'd0, blk_count}, 32'd1);
    chk("a_drained", {31'd0, out_valid}, 32'd0);

    // Stalled consumer: third block dropped
    @(posedge clk); #1;
    out_ready = 1'b0;
    expect_blk(32'h10101010, 32'h11111111, 32'h12121212, 32'h13131313);
    expect_blk(32'h20202020, 32'h21212121, 32'h22222222, 32'h23232323);
    push_blk(B1);
    push_blk(B2);
    @(negedge clk);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_data = B3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_still_full", {31'd0, in_ready}, 32'd0);
    chk("ovf_head", out_data, 32'h10101010);

    // Toggling out_ready drains both blocks without loss or duplication
    @(posedge clk); #1;
    for (int i = 0; i < 40 && out_valid; i++) begin
      out_ready = (i % 2 == 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    @(negedge clk);
    chk("toggle_drained", {31'd0, out_valid}, 32'd0);
    chk("toggle_blk_count", {16'd0, blk_count}, 32'd3);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Pop of last word coincides with a push at count=1
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_blk(32'h40404040, 32'h41414141, 32'h42424242, 32'h43434343);
    expect_blk(32'h50505050, 32'h51515151, 32'h52525252, 32'h53535353);
    push_blk(B4);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_swap_last", {31'd0, out_last}, 32'd1);
    push_blk(B5);
    @(negedge clk);
    chk("swap_word0", out_data, 32'h50505050);
    chk("swap_count1", {31'd0, in_ready}, 32'd1);
    chk("swap_valid", {31'd0, out_valid}, 32'd1);
    chk("swap_blk_count", {16'd0, blk_count}, 32'd4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("swap_drained", {31'd0, out_valid}, 32'd0);

    // Reset mid-block with the FIFO full
    @(posedge clk); #1;
    out_ready = 1'b0;
    expect_blk(32'h60606060, 32'h61616161, 32'h62626262, 32'h63636363);
    expect_blk(32'h70707070, 32'h71717171, 32'h72727272, 32'h73737373);
    push_blk(B6);
    push_blk(B7);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_word2", out_data, 32'h62626262);
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    chk("pre_rst_ovf", {31'd0, overflow}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_msw.delete();
    q_lsw.delete();
    @(negedge clk);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_overflow", {31'd0, overflow}, 32'd0);
    chk("mid_rst_blk_count", {16'd0, blk_count}, 32'd0);

    // Normal operation resumes after reset
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_blk(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
    push_blk(B0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("post_rst_blk_count", {16'd0, blk_count}, 32'd1);
    chk("msw_queue_empty", q_msw.size(), 32'd0);
    chk("lsw_queue_empty", q_lsw.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
